// File: rtl/toivoh_on_chip_memory_core_pkg.sv
// rtl/toivoh_on_chip_memory_core_pkg.sv - shared sizes and command encodings for the memory test core
package toivoh_on_chip_memory_core_pkg;
   localparam int ADDR_BITS   = 4;
   localparam int DATA_BITS   = 16;
   localparam int SERIAL_BITS = 4;

   typedef enum logic [2:0] {
      CMD_NOP       = 3'd0,
      CMD_LOAD_ADDR = 3'd1,
      CMD_SHIFT_IN  = 3'd2,
      CMD_WRITE     = 3'd3,
      CMD_READ      = 3'd4,
      CMD_SHIFT_OUT = 3'd5
   } cmd_t;
endpackage

// File: rtl/toivoh_on_chip_memory_core_on_chip_mem.sv
// rtl/toivoh_on_chip_memory_core_on_chip_mem.sv - unreset word array with one write port and an async read tap
module on_chip_mem #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_BITS = 16
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [DATA_BITS-1:0] wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [DATA_BITS-1:0] rdata
);
   logic [DATA_BITS-1:0] all_data [2**ADDR_BITS];

   // The read tap is captured by the caller's register, so a write followed
   // by a read of the same word on the next edge sees the new data.
   always_ff @(posedge clk) begin
      if (we) all_data[waddr] <= wdata;
   end

   assign rdata = all_data[raddr];
endmodule

// File: rtl/toivoh_on_chip_memory_core.sv
// rtl/toivoh_on_chip_memory_core.sv - command decode, address counter and serial shift registers around the array
module toivoh_on_chip_memory_core
   import toivoh_on_chip_memory_core_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   logic [ADDR_BITS-1:0]   addr;
   logic [DATA_BITS-1:0]   wreg;
   logic [DATA_BITS-1:0]   rreg;
   logic [DATA_BITS-1:0]   rdata;
   logic [SERIAL_BITS-1:0] nib;
   logic [2:0]             cmd;
   logic                   we;
   logic                   unused_bits;

   assign cmd = ui_in[2:0];
   assign nib = ui_in[4 +: SERIAL_BITS];
   assign we  = ena && !rst && (cmd == CMD_WRITE);

   on_chip_mem #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (addr),
      .wdata (wreg),
      .raddr (addr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
         wreg <= '0;
         rreg <= '0;
      end else if (ena) begin
         case (cmd)
            CMD_LOAD_ADDR: addr <= ADDR_BITS'(nib);
            CMD_SHIFT_IN:  wreg <= {wreg[DATA_BITS-SERIAL_BITS-1:0], nib};
            CMD_WRITE:     addr <= addr + ADDR_BITS'(1);
            CMD_READ: begin
               rreg <= rdata;
               addr <= addr + ADDR_BITS'(1);
            end
            CMD_SHIFT_OUT: rreg <= {rreg[DATA_BITS-SERIAL_BITS-1:0], {SERIAL_BITS{1'b0}}};
            default: ;
         endcase
      end
   end

   // Outputs come straight from state registers, so they trail commands by one edge.
   assign uo_out  = {4'(addr), 4'(rreg[DATA_BITS-1 -: SERIAL_BITS])};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   assign unused_bits = ^{uio_in, ui_in[7:3]};
endmodule

// File: tb/tb_toivoh_on_chip_memory_core.sv
// tb/tb_toivoh_on_chip_memory_core.sv - directed self-checking bench for the memory test core
module tb_toivoh_on_chip_memory_core;
   import toivoh_on_chip_memory_core_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int passed = 0;
   int total = 0;

   toivoh_on_chip_memory_core dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic do_cmd(input logic [2:0] c, input logic [3:0] n);
      @(negedge clk);
      ui_in = {n, 1'b0, c};
      @(posedge clk);
      #1;
      ui_in = 8'h00;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   initial begin
      // Reset with ena high for two cycles
      rst = 1'b1;
      ena = 1'b1;
      do_cmd(CMD_NOP, 4'h0);
      do_cmd(CMD_NOP, 4'h0);
      check("reset_uo_out", uo_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);
      rst = 1'b0;

      // Write 0xABCD to address 3 and read it back serially
      do_cmd(CMD_LOAD_ADDR, 4'h3);
      check("load_addr3", uo_out, 8'h30);
      do_cmd(CMD_SHIFT_IN, 4'hA);
      do_cmd(CMD_SHIFT_IN, 4'hB);
      do_cmd(CMD_SHIFT_IN, 4'hC);
      do_cmd(CMD_SHIFT_IN, 4'hD);
      do_cmd(CMD_WRITE, 4'h0);
      check("write_incr_addr", uo_out, 8'h40);
      do_cmd(CMD_LOAD_ADDR, 4'h3);
      do_cmd(CMD_READ, 4'h0);
      check("read_abcd_0", uo_out, 8'h4A);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("read_abcd_1", uo_out, 8'h4B);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("read_abcd_2", uo_out, 8'h4C);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("read_abcd_3", uo_out, 8'h4D);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("read_abcd_drain", uo_out, 8'h40);

      // Reserved command must not disturb anything
      do_cmd(3'd6, 4'h9);
      check("reserved_cmd6", uo_out, 8'h40);
      do_cmd(3'd7, 4'h2);
      check("reserved_cmd7", uo_out, 8'h40);

      // Fill every word with 0x1111*k using auto-increment
      do_cmd(CMD_LOAD_ADDR, 4'h0);
      for (int k = 0; k < 16; k++) begin
         for (int s = 0; s < 4; s++) do_cmd(CMD_SHIFT_IN, 4'(k));
         do_cmd(CMD_WRITE, 4'h0);
      end
      check("sweep_addr_wrap", uo_out, 8'h00);
      for (int k = 0; k < 16; k++) begin
         do_cmd(CMD_READ, 4'h0);
         check($sformatf("sweep_read_%0d", k), uo_out, {4'((k + 1) % 16), 4'(k)});
      end

      // ena low: LOAD_ADDR and WRITE must be ignored
      ena = 1'b0;
      do_cmd(CMD_LOAD_ADDR, 4'h7);
      do_cmd(CMD_WRITE, 4'h0);
      check("ena_low_hold", uo_out, 8'h0F);
      ena = 1'b1;
      do_cmd(CMD_READ, 4'h0);
      check("ena_low_mem0_intact", uo_out, 8'h10);
      do_cmd(CMD_LOAD_ADDR, 4'h7);
      do_cmd(CMD_READ, 4'h0);
      check("ena_low_mem7_intact", uo_out, 8'h87);

      // Write 0x5A5A to address 2 and read it back immediately
      do_cmd(CMD_LOAD_ADDR, 4'h2);
      do_cmd(CMD_SHIFT_IN, 4'h5);
      do_cmd(CMD_SHIFT_IN, 4'hA);
      do_cmd(CMD_SHIFT_IN, 4'h5);
      do_cmd(CMD_SHIFT_IN, 4'hA);
      do_cmd(CMD_WRITE, 4'h0);
      do_cmd(CMD_LOAD_ADDR, 4'h2);
      do_cmd(CMD_READ, 4'h0);
      check("b2b_0", uo_out, 8'h35);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("b2b_1", uo_out, 8'h3A);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("b2b_2", uo_out, 8'h35);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("b2b_3", uo_out, 8'h3A);

      // Reset mid-shift; the WRITE issued alongside reset must be dropped
      do_cmd(CMD_SHIFT_IN, 4'h9);
      do_cmd(CMD_SHIFT_IN, 4'h8);
      rst = 1'b1;
      do_cmd(CMD_WRITE, 4'h0);
      rst = 1'b0;
      check("midreset_uo_out", uo_out, 8'h00);
      do_cmd(CMD_SHIFT_IN, 4'h1);
      do_cmd(CMD_SHIFT_IN, 4'h2);
      do_cmd(CMD_SHIFT_IN, 4'h3);
      do_cmd(CMD_SHIFT_IN, 4'h4);
      do_cmd(CMD_WRITE, 4'h0);
      check("midreset_write_addr", uo_out, 8'h10);
      do_cmd(CMD_LOAD_ADDR, 4'h0);
      do_cmd(CMD_READ, 4'h0);
      check("midreset_read_0", uo_out, 8'h11);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("midreset_read_1", uo_out, 8'h12);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("midreset_read_2", uo_out, 8'h13);
      do_cmd(CMD_SHIFT_OUT, 4'h0);
      check("midreset_read_3", uo_out, 8'h14);
      do_cmd(CMD_LOAD_ADDR, 4'h3);
      do_cmd(CMD_READ, 4'h0);
      check("midreset_mem3_intact", uo_out, 8'h43);
      do_cmd(CMD_LOAD_ADDR, 4'h2);
      do_cmd(CMD_READ, 4'h0);
      check("midreset_mem2_intact", uo_out, 8'h35);
      do_cmd(CMD_LOAD_ADDR, 4'hF);
      do_cmd(CMD_READ, 4'h0);
      check("midreset_mem15_intact", uo_out, 8'h0F);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
